// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first, with a one-entry valid/ready holding register.
// The asynchronous rx line is double-flopped. Framing and overrun errors are sticky.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   rx_s;

    // Synchroniser presets to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // Clear first so that a flag set later in this cycle takes priority.
        if (clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_MID) begin
                    baud_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                        // A byte being taken this cycle frees the slot for the new one.
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d     = S_BREAK;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_BREAK: begin
                baud_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a line driver sends 8N1 frames, a monitor records
// delivered bytes and flag edges, and each scenario compares against its own expectations.
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int valid_rises = 0;
    int fe_rises = 0;
    int data_changes = 0;
    int last_rise = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_fe = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
        .clr_err(clr_err), .busy(busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, between input changes and the active edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid && !prev_valid) begin
            valid_rises++;
            last_rise = cyc;
        end
        if (frame_err && !prev_fe) fe_rises++;
        if (prev_valid && !prev_ready && rx_valid && rx_data != prev_data) data_changes++;
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_fe    = frame_err;
        prev_data  = rx_data;
    end

    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(d[i], C);
        hold(stop, C);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_data); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {frame_err, overrun}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset_n = 1'b1;
        hold(1'b1, C);
        total++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", busy, rx_valid); end
    endtask

    task automatic test_basic();
        int start_cyc;
        int rises0;
        logic [7:0] d;
        rx_ready = 1'b1;
        rises0 = valid_rises;
        start_cyc = cyc;
        send_frame(8'h55, 1'b1); exp_q.push_back(8'h55);
        hold(1'b1, 2 * C);
        total++; if (last_rise - start_cyc < C / 2 + 9 * C + 1 || last_rise - start_cyc > C / 2 + 9 * C + 7) begin
            bad++; $display("FAIL latency got=%0d want=%0d..%0d", last_rise - start_cyc, C / 2 + 9 * C + 1, C / 2 + 9 * C + 7);
        end
        send_frame(8'hA3, 1'b1); exp_q.push_back(8'hA3);
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1); exp_q.push_back(d);
            hold(1'b1, $urandom_range(0, C));
        end
        hold(1'b1, 2 * C);
        total++; if (valid_rises - rises0 !== exp_q.size()) begin bad++; $display("FAIL basic_pulses got=%0d want=%0d", valid_rises - rises0, exp_q.size()); end
        total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            total++;
            if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL basic_byte got=%h want=%h", got_q[0], exp_q[0]); end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        got_q.delete(); exp_q.delete();
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {frame_err, overrun}); end
    endtask

    task automatic test_glitch();
        int rises0;
        int len;
        rises0 = valid_rises;
        hold(1'b0, 4);
        hold(1'b1, 1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy got=%b want=1", busy); end
        hold(1'b1, 2 * C);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", busy); end
        len = $urandom_range(1, 5);
        hold(1'b0, len);
        hold(1'b1, 2 * C);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_rand_idle len=%0d got=%b want=0", len, busy); end
        total++; if (valid_rises !== rises0) begin bad++; $display("FAIL glitch_valid got=%0d want=%0d", valid_rises - rises0, 0); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b want=00", {frame_err, overrun}); end
    endtask

    task automatic test_frame_err();
        int rises0;
        int fe0;
        rises0 = valid_rises;
        fe0 = fe_rises;
        send_frame(8'h3C, 1'b0);
        hold(1'b1, 2 * C);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b want=1", frame_err); end
        total++; if (fe_rises - fe0 !== 1) begin bad++; $display("FAIL ferr_edges got=%0d want=1", fe_rises - fe0); end
        total++; if (valid_rises !== rises0) begin bad++; $display("FAIL ferr_novalid got=%0d want=0", valid_rises - rises0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_idle got=%b want=0", busy); end
        pulse_clr();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clr got=%b want=0", frame_err); end
        send_frame(8'h81, 1'b1);
        hold(1'b1, 2 * C);
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL ferr_next_count got=%0d want=1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== 8'h81) begin bad++; $display("FAIL ferr_next_byte got=%h want=81", got_q[0]); end
        end
        got_q.delete();
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        hold(1'b1, C);
        total++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin bad++; $display("FAIL ovr_first got=%b/%h want=1/11", rx_valid, rx_data); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0", overrun); end
        send_frame(8'h22, 1'b1);
        hold(1'b1, 2 * C);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
        total++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_kept got=%b/%h want=1/11", rx_valid, rx_data); end
        total++; if (data_changes !== 0) begin bad++; $display("FAIL ovr_stable got=%0d want=0", data_changes); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ovr_ferr got=%b want=0", frame_err); end
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", rx_valid); end
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin bad++; $display("FAIL ovr_taken count=%0d want one byte 11", got_q.size()); end
        got_q.delete();
        pulse_clr();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", overrun); end
    endtask

    task automatic test_break();
        int rises0;
        int fe0;
        logic [7:0] d;
        rises0 = valid_rises;
        fe0 = fe_rises;
        hold(1'b0, 30 * C);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL brk_held got=%b want=1", busy); end
        total++; if (fe_rises - fe0 !== 1) begin bad++; $display("FAIL brk_one_ferr got=%0d want=1", fe_rises - fe0); end
        total++; if (valid_rises !== rises0) begin bad++; $display("FAIL brk_novalid got=%0d want=0", valid_rises - rises0); end
        hold(1'b1, C);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL brk_release got=%b want=0", busy); end
        pulse_clr();
        d = 8'($urandom_range(0, 255));
        send_frame(d, 1'b1);
        hold(1'b1, 2 * C);
        total++; if (got_q.size() !== 1 || got_q[0] !== d) begin bad++; $display("FAIL brk_recover count=%0d want one byte %h", got_q.size(), d); end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        logic [7:0] f;
        d = 8'($urandom_range(1, 255));
        f = 8'hF0;
        rx_ready = 1'b0;
        send_frame(d, 1'b1);
        hold(1'b1, C);
        total++; if (rx_valid !== 1'b1 || rx_data !== d) begin bad++; $display("FAIL rst_pre got=%b/%h want=1/%h", rx_valid, rx_data, d); end
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(f[i], C);
        hold(f[4], C / 2);
        reset_n = 1'b0;
        #1;
        total++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%b/%h want=0/00", rx_valid, rx_data); end
        total++; if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL rst_mid_ctl got=%b%b%b want=000", busy, frame_err, overrun); end
        hold(1'b1, C);
        reset_n = 1'b1;
        rx_ready = 1'b1;
        hold(1'b1, C);
        got_q.delete();
        send_frame(8'h0F, 1'b1);
        hold(1'b1, 2 * C);
        total++; if (got_q.size() !== 1 || got_q[0] !== 8'h0F) begin bad++; $display("FAIL rst_next count=%0d want one byte 0f", got_q.size()); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL rst_next_flags got=%b want=00", {frame_err, overrun}); end
        got_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_break();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
